// File: rtl/gen_step_sequencer.sv
// Multi-channel step sequencer: shared step position advanced per tempo tick,
// per-channel pattern/probability gating against a Galois LFSR, fixed-length gates.
module gen_step_sequencer #(
   parameter int unsigned NUM_CHANNELS = 4,
   parameter int unsigned NUM_STEPS    = 16,
   parameter int unsigned PROB_W       = 8,
   parameter int unsigned GATE_LEN     = 4,
   parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            run,
   input  logic                            step_tick,
   input  logic [1:0]                      mode,
   input  logic [$clog2(NUM_STEPS):0]      length,
   input  logic                            cfg_we,
   input  logic [$clog2(NUM_CHANNELS)-1:0] cfg_ch,
   input  logic [NUM_STEPS-1:0]            cfg_pattern,
   input  logic [PROB_W-1:0]               cfg_prob,
   output logic [$clog2(NUM_STEPS)-1:0]    step_idx,
   output logic                            step_strobe,
   output logic [NUM_CHANNELS-1:0]         gate,
   output logic                            running
);

   localparam int unsigned SW = $clog2(NUM_STEPS);
   localparam int unsigned LW = SW + 1;
   localparam int unsigned CW = $clog2(NUM_CHANNELS);
   localparam int unsigned GW = $clog2(GATE_LEN + 1);
   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

   state_t                state_q, state_d;
   logic [SW-1:0]         pos_q, pos_d;
   logic                  dir_up_q, dir_up_d;
   logic [15:0]           lfsr_q, lfsr_d;
   logic [NUM_STEPS-1:0]  pattern_q [NUM_CHANNELS];
   logic [NUM_STEPS-1:0]  pattern_d [NUM_CHANNELS];
   logic [PROB_W-1:0]     prob_q [NUM_CHANNELS];
   logic [PROB_W-1:0]     prob_d [NUM_CHANNELS];
   logic [GW-1:0]         cnt_q [NUM_CHANNELS];
   logic [GW-1:0]         cnt_d [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] gate_q, gate_d;
   logic [SW-1:0]         step_idx_q, step_idx_d;
   logic                  step_strobe_q, step_strobe_d;
   logic                  running_q, running_d;

   logic [LW-1:0]         len_eff;
   logic [SW-1:0]         last_pos;
   logic [SW-1:0]         start_pos;
   logic [SW-1:0]         fire_pos;
   logic [LW-1:0]         rnd_acc;
   logic [SW-1:0]         rnd_pos;
   logic [PROB_W-1:0]     r_c;
   logic [NUM_CHANNELS-1:0] fire_ch;
   logic                  fire_now;

   assign len_eff   = (length == '0 || length > LW'(NUM_STEPS)) ? LW'(NUM_STEPS) : length;
   assign last_pos  = SW'(len_eff - LW'(1));
   assign start_pos = (mode == 2'd1) ? last_pos : '0;
   // A position left out of range by a length change never fires; it snaps to the start point.
   assign fire_pos  = (LW'(pos_q) >= len_eff) ? start_pos : pos_q;

   // Random target: masked LFSR byte reduced modulo the active length
   always_comb begin
      rnd_acc = LW'(lfsr_q[8 +: SW]);
      for (int unsigned i = 0; i < NUM_STEPS; i++) begin
         if (rnd_acc >= len_eff) rnd_acc = rnd_acc - len_eff;
      end
      rnd_pos = SW'(rnd_acc);
   end

   // Per-channel fire decision from pattern bit and rotated LFSR threshold
   always_comb begin
      fire_ch = '0;
      r_c     = '0;
      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         r_c = PROB_W'({lfsr_q, lfsr_q} >> ((3 * c) % 16));
         fire_ch[c] = pattern_q[c][fire_pos] && (prob_q[c] == '1 || r_c < prob_q[c]);
      end
   end

   // Next-state, position advance, gate counters and config writes
   always_comb begin
      state_d       = state_q;
      pos_d         = pos_q;
      dir_up_d      = dir_up_q;
      lfsr_d        = lfsr_q;
      step_idx_d    = step_idx_q;
      step_strobe_d = 1'b0;
      pattern_d     = pattern_q;
      prob_d        = prob_q;
      cnt_d         = cnt_q;
      fire_now      = 1'b0;

      case (state_q)
         S_IDLE: begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) cnt_d[c] = '0;
            if (run) begin
               state_d  = S_RUN;
               pos_d    = start_pos;
               dir_up_d = 1'b1;
            end
         end
         S_RUN: begin
            for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
               if (cnt_q[c] != '0) cnt_d[c] = cnt_q[c] - GW'(1);
            end
            if (!run) state_d = S_IDLE;
            else if (step_tick) fire_now = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase

      if (fire_now) begin
         step_strobe_d = 1'b1;
         step_idx_d    = fire_pos;
         lfsr_d        = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
         for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            if (fire_ch[c]) cnt_d[c] = GW'(GATE_LEN);
         end
         case (mode)
            2'd0: pos_d = (fire_pos == last_pos) ? '0 : fire_pos + SW'(1);
            2'd1: pos_d = (fire_pos == '0) ? last_pos : fire_pos - SW'(1);
            2'd2: begin
               if (len_eff == LW'(1)) begin
                  pos_d = '0;
               end else if (dir_up_q ? (fire_pos == last_pos) : (fire_pos != '0)) begin
                  pos_d    = fire_pos - SW'(1);
                  dir_up_d = 1'b0;
               end else begin
                  pos_d    = fire_pos + SW'(1);
                  dir_up_d = 1'b1;
               end
            end
            default: pos_d = rnd_pos;
         endcase
      end

      for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
         if (cfg_we && cfg_ch == CW'(c)) begin
            pattern_d[c] = cfg_pattern;
            prob_d[c]    = cfg_prob;
         end
      end

      for (int unsigned c = 0; c < NUM_CHANNELS; c++) gate_d[c] = (cnt_d[c] != '0);
      running_d = (state_d == S_RUN);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         pos_q         <= '0;
         dir_up_q      <= 1'b1;
         lfsr_q        <= LFSR_SEED;
         step_idx_q    <= '0;
         step_strobe_q <= 1'b0;
         gate_q        <= '0;
         running_q     <= 1'b0;
         for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            pattern_q[c] <= '0;
            prob_q[c]    <= '1;
            cnt_q[c]     <= '0;
         end
      end else begin
         state_q       <= state_d;
         pos_q         <= pos_d;
         dir_up_q      <= dir_up_d;
         lfsr_q        <= lfsr_d;
         step_idx_q    <= step_idx_d;
         step_strobe_q <= step_strobe_d;
         gate_q        <= gate_d;
         running_q     <= running_d;
         for (int unsigned c = 0; c < NUM_CHANNELS; c++) begin
            pattern_q[c] <= pattern_d[c];
            prob_q[c]    <= prob_d[c];
            cnt_q[c]     <= cnt_d[c];
         end
      end
   end

   assign step_idx    = step_idx_q;
   assign step_strobe = step_strobe_q;
   assign gate        = gate_q;
   assign running     = running_q;

endmodule

// File: tb/tb_gen_step_sequencer.sv
// Bench for gen_step_sequencer: vector table, directed corner sequences and
// randomized traffic against a cycle-level behavioural model.
module tb_gen_step_sequencer;

   localparam int unsigned NCH = 4;
   localparam int unsigned NST = 16;
   localparam int unsigned GL  = 4;

   logic        clk = 1'b0;
   logic        rst, run, step_tick, cfg_we;
   logic [1:0]  mode;
   logic [4:0]  length;
   logic [1:0]  cfg_ch;
   logic [15:0] cfg_pattern;
   logic [7:0]  cfg_prob;
   logic [3:0]  step_idx;
   logic        step_strobe;
   logic [3:0]  gate;
   logic        running;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   gen_step_sequencer dut (
      .clk(clk), .rst(rst), .run(run), .step_tick(step_tick), .mode(mode),
      .length(length), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_pattern(cfg_pattern),
      .cfg_prob(cfg_prob), .step_idx(step_idx), .step_strobe(step_strobe),
      .gate(gate), .running(running)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] lfsr_next(input logic [15:0] v);
      return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [15:0] rotr(input logic [15:0] v, input int s);
      int k;
      k = s % 16;
      if (k == 0) return v;
      return (v >> k) | (v << (16 - k));
   endfunction

   function automatic int eff_len(input int l);
      return (l == 0 || l > NST) ? NST : l;
   endfunction

   // Behavioural model: gates tracked as remaining-cycle counts, positions as integers
   bit          m_run, m_up, m_strobe, m_running;
   int          m_pos, m_idx;
   logic [15:0] m_lfsr;
   logic [15:0] m_pat [NCH];
   int          m_prob [NCH];
   int          m_left [NCH];

   always @(posedge clk or posedge rst) begin
      int L, st, p, r;
      if (rst) begin
         m_run = 0; m_up = 1; m_strobe = 0; m_running = 0;
         m_pos = 0; m_idx = 0; m_lfsr = 16'hACE1;
         for (int c = 0; c < NCH; c++) begin
            m_pat[c] = '0; m_prob[c] = 255; m_left[c] = 0;
         end
      end else begin
         L  = eff_len(int'(length));
         st = (mode == 2'd1) ? L - 1 : 0;
         m_strobe = 0;
         if (!m_run) begin
            for (int c = 0; c < NCH; c++) m_left[c] = 0;
            if (run) begin m_run = 1; m_pos = st; m_up = 1; end
         end else begin
            for (int c = 0; c < NCH; c++) if (m_left[c] > 0) m_left[c]--;
            if (!run) m_run = 0;
            else if (step_tick) begin
               p = (m_pos >= L) ? st : m_pos;
               for (int c = 0; c < NCH; c++) begin
                  r = int'(rotr(m_lfsr, 3 * c) & 16'h00FF);
                  if (m_pat[c][p] && (m_prob[c] == 255 || r < m_prob[c])) m_left[c] = GL;
               end
               m_idx = p; m_strobe = 1;
               case (mode)
                  2'd0: m_pos = (p + 1) % L;
                  2'd1: m_pos = (p + L - 1) % L;
                  2'd2: begin
                     if (L == 1) m_pos = 0;
                     else begin
                        if (m_up && p == L - 1) m_up = 0;
                        else if (!m_up && p == 0) m_up = 1;
                        m_pos = m_up ? p + 1 : p - 1;
                     end
                  end
                  default: m_pos = (int'(m_lfsr[15:8]) % NST) % L;
               endcase
               m_lfsr = lfsr_next(m_lfsr);
            end
         end
         if (cfg_we) begin
            m_pat[cfg_ch]  = cfg_pattern;
            m_prob[cfg_ch] = int'(cfg_prob);
         end
         m_running = m_run;
      end
   end

   function automatic logic [3:0] m_gate();
      logic [3:0] g;
      for (int c = 0; c < NCH; c++) g[c] = (m_left[c] > 0);
      return g;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_step_idx", 32'(step_idx), 32'(m_idx));
         chk("cyc_strobe", 32'(step_strobe), 32'(m_strobe));
         chk("cyc_gate", 32'(gate), 32'(m_gate()));
         chk("cyc_running", 32'(running), 32'(m_running));
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic tick();
      step_tick = 1'b1; cyc(1); step_tick = 1'b0;
   endtask

   task automatic cfg(input logic [1:0] ch, input logic [15:0] pat, input logic [7:0] pr);
      cfg_we = 1'b1; cfg_ch = ch; cfg_pattern = pat; cfg_prob = pr;
      cyc(1); cfg_we = 1'b0;
   endtask

   task automatic restart(input logic [1:0] m, input logic [4:0] l);
      run = 1'b0; cyc(2);
      mode = m; length = l; run = 1'b1; cyc(1);
   endtask

   task automatic do_reset();
      run = 1'b0; rst = 1'b1; cyc(1); rst = 1'b0;
   endtask

   task automatic count_gates(input int n, output int hits);
      hits = 0;
      for (int i = 0; i < n; i++) begin
         tick(); hits += int'(gate[0]); cyc(4);
      end
   endtask

   typedef struct packed {
      logic [1:0]       mode;
      logic [4:0]       len;
      logic [0:7][3:0]  seq;
   } vec_t;

   vec_t vecs [8];

   initial begin
      int hi, cnt, exp_cnt;
      logic [15:0] gl;

      vecs[0] = '{mode: 2'd0, len: 5'd4,  seq: 32'h0123_0123};
      vecs[1] = '{mode: 2'd2, len: 5'd4,  seq: 32'h0123_2101};
      vecs[2] = '{mode: 2'd1, len: 5'd4,  seq: 32'h3210_3210};
      vecs[3] = '{mode: 2'd0, len: 5'd0,  seq: 32'h0123_4567};
      vecs[4] = '{mode: 2'd1, len: 5'd20, seq: 32'hFEDC_BA98};
      vecs[5] = '{mode: 2'd2, len: 5'd1,  seq: 32'h0000_0000};
      vecs[6] = '{mode: 2'd2, len: 5'd2,  seq: 32'h0101_0101};
      vecs[7] = '{mode: 2'd0, len: 5'd3,  seq: 32'h0120_1201};

      rst = 1'b1; run = 1'b0; step_tick = 1'b0; cfg_we = 1'b0; mode = 2'd0;
      length = 5'd4; cfg_ch = 2'd0; cfg_pattern = '0; cfg_prob = '0;
      cyc(2);
      chk_en = 1'b1;
      chk("rst_step_idx", 32'(step_idx), 0);
      chk("rst_strobe", 32'(step_strobe), 0);
      chk("rst_gate", 32'(gate), 0);
      chk("rst_running", 32'(running), 0);
      rst = 1'b0;

      // Vector table: traversal order and single-step pattern gating
      cfg(2'd0, 16'h0001, 8'hFF);
      for (int v = 0; v < 8; v++) begin
         restart(vecs[v].mode, vecs[v].len);
         chk("tbl_running", 32'(running), 1);
         for (int k = 0; k < 8; k++) begin
            tick();
            chk("tbl_step_idx", 32'(step_idx), 32'(vecs[v].seq[k]));
            chk("tbl_strobe", 32'(step_strobe), 1);
            hi = int'(gate[0]);
            repeat (4) begin cyc(1); hi += int'(gate[0]); end
            chk("tbl_gate_len", 32'(hi), (vecs[v].seq[k] == 4'd0) ? 32'(GL) : 0);
         end
      end

      // Probability thresholds
      do_reset();
      cfg(2'd0, 16'hFFFF, 8'h00);
      restart(2'd0, 5'd0);
      count_gates(16, cnt);
      chk("prob_zero", 32'(cnt), 0);
      cfg(2'd0, 16'hFFFF, 8'hFF);
      count_gates(16, cnt);
      chk("prob_full", 32'(cnt), 16);
      do_reset();
      cfg(2'd0, 16'hFFFF, 8'h80);
      restart(2'd0, 5'd0);
      gl = 16'hACE1; exp_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (gl[7:0] < 8'h80) exp_cnt++;
         gl = lfsr_next(gl);
      end
      count_gates(16, cnt);
      chk("prob_half", 32'(cnt), 32'(exp_cnt));

      // Retrigger every 2 cycles keeps the gate high, then it falls GATE_LEN after the last fire
      cfg(2'd0, 16'hFFFF, 8'hFF);
      restart(2'd0, 5'd4);
      for (int i = 0; i < 8; i++) begin
         tick(); chk("retrig_hi_a", 32'(gate[0]), 1);
         cyc(1); chk("retrig_hi_b", 32'(gate[0]), 1);
      end
      cyc(1); chk("retrig_tail2", 32'(gate[0]), 1);
      cyc(1); chk("retrig_tail3", 32'(gate[0]), 1);
      cyc(1); chk("retrig_fall", 32'(gate[0]), 0);

      // Asynchronous reset while a gate is active
      tick(); tick(); tick();
      chk("pre_rst_idx", 32'(step_idx), 2);
      chk("pre_rst_gate", 32'(gate[0]), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_gate", 32'(gate), 0);
      chk("async_rst_running", 32'(running), 0);
      chk("async_rst_idx", 32'(step_idx), 0);
      cyc(1); rst = 1'b0;
      cyc(1);
      cfg(2'd0, 16'hFFFF, 8'hFF);
      tick();
      chk("post_rst_strobe", 32'(step_strobe), 1);
      chk("post_rst_idx", 32'(step_idx), 0);
      chk("post_rst_gate", 32'(gate[0]), 1);
      tick();
      chk("post_rst_idx2", 32'(step_idx), 1);

      // Config write coincident with a tick uses the old pattern
      cfg(2'd0, 16'h0000, 8'hFF);
      cyc(5);
      step_tick = 1'b1; cfg_we = 1'b1; cfg_ch = 2'd0; cfg_pattern = 16'hFFFF; cfg_prob = 8'hFF;
      cyc(1);
      step_tick = 1'b0; cfg_we = 1'b0;
      chk("cfg_same_strobe", 32'(step_strobe), 1);
      chk("cfg_same_gate", 32'(gate[0]), 0);
      cyc(4);
      tick();
      chk("cfg_next_gate", 32'(gate[0]), 1);

      // Length cut below the current position
      restart(2'd0, 5'd16);
      repeat (10) tick();
      chk("len_cut_pre", 32'(step_idx), 9);
      length = 5'd4;
      tick();
      chk("len_cut_next", 32'(step_idx), 0);
      tick();
      chk("len_cut_next2", 32'(step_idx), 1);

      // Stop: gates clear, ticks ignored, step index holds
      run = 1'b0; cyc(1);
      chk("stop_running", 32'(running), 0);
      cyc(5);
      chk("stop_gate", 32'(gate), 0);
      tick();
      chk("idle_tick_strobe", 32'(step_strobe), 0);
      chk("idle_tick_idx", 32'(step_idx), 1);

      // Randomized traffic; the per-cycle model comparison does the checking
      for (int seg = 0; seg < 24; seg++) begin
         mode = 2'($urandom_range(0, 3));
         length = 5'($urandom_range(0, 31));
         run = 1'b1;
         for (int i = 0; i < 120; i++) begin
            step_tick   = ($urandom_range(0, 2) == 0);
            cfg_we      = ($urandom_range(0, 9) == 0);
            cfg_ch      = 2'($urandom_range(0, 3));
            cfg_pattern = 16'($urandom);
            case ($urandom_range(0, 2))
               0:       cfg_prob = 8'h00;
               1:       cfg_prob = 8'hFF;
               default: cfg_prob = 8'($urandom);
            endcase
            if ($urandom_range(0, 29) == 0) length = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 59) == 0) run = ~run;
            cyc(1);
         end
         step_tick = 1'b0; cfg_we = 1'b0; run = 1'b0;
         cyc(3);
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gen_step_sequencer.md
Name: gen_step_sequencer

Overview:
Parametrised multi-channel step sequencer core for the generative sequencer top level. It advances a shared step position on each tempo tick in one of four traversal modes. Per channel, it gates each step through a stored pattern bit and a probability threshold compared against an internal LFSR. Its outputs are per-channel gate pulses and the current step index, which drive the note/trigger stage.

Parameters:
NUM_CHANNELS, 4, number of independent gate channels
NUM_STEPS, 16, pattern length capacity (power of two, >=2)
PROB_W, 8, probability threshold width
GATE_LEN, 4, gate pulse length in clk cycles (>=1)
LFSR_SEED, 16'hACE1, LFSR reset value (non-zero)

Ports:
clk  in  1  system clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
run  in  1  level; 1 = sequencer running
step_tick  in  1  one-cycle tempo pulse
mode  in  2  0 forward, 1 reverse, 2 ping-pong, 3 random
length  in  $clog2(NUM_STEPS)+1  active step count; 0 or >NUM_STEPS treated as NUM_STEPS
cfg_we  in  1  config write strobe
cfg_ch  in  $clog2(NUM_CHANNELS)  channel to write
cfg_pattern  in  NUM_STEPS  pattern bits, bit i = step i
cfg_prob  in  PROB_W  probability threshold
step_idx  out  $clog2(NUM_STEPS)  step most recently fired
step_strobe  out  1  one-cycle pulse when a step fires
gate  out  NUM_CHANNELS  per-channel gate outputs
running  out  1  1 while in RUN

Behaviour:
- Reset values: step_idx=0, step_strobe=0, gate=0, running=0, lfsr=LFSR_SEED, all patterns=0, all probs=all-ones, FSM=IDLE, pingpong direction=up. Reset mid-run aborts any active gates on the same edge (async).
- FSM IDLE->RUN when run=1; RUN->IDLE when run=0. On entry to RUN, position loads start: 0 for modes 0/2/3, length-1 for mode 1. running registered (1 cycle after run changes).
- In RUN, each step_tick fires the current position, then advances the position; the next tick fires the new position. Output latency is 1 cycle: step_strobe, step_idx and gate rise on the clk edge after the tick cycle.
- Fire rule, channel c: pattern[c][pos]=1 AND (prob[c]==all-ones OR r_c < prob[c]). r_c = low PROB_W bits of the lfsr rotated right by 3*c, sampled before the LFSR advances.
- LFSR: 16-bit Galois, taps 16'hB400; advances once per step_tick in RUN only.
- Gate: on fire, counter c loads GATE_LEN and gate[c]=1 for exactly GATE_LEN cycles. A re-fire while active reloads the counter (gate stays high). A tick that does not fire channel c leaves an active gate running.
- Advance rules, with L = effective length:
  - forward: pos+1, wraps L-1->0.
  - reverse: pos-1, wraps 0->L-1.
  - ping-pong: endpoints are not repeated (L=4: 0,1,2,3,2,1,0,1...). L=1 stays at 0.
  - random: n = lfsr[15:8] masked to step width; n>=L ? n-L (repeat subtraction until n<L) : n.
- If pos >= L after a length change, the next advance goes to 0 (modes 0/2/3) or L-1 (mode 1). A mode change takes effect at the next advance.
- Stop: on the cycle run=0 is sampled, the FSM goes IDLE and all gates and counters clear on the following edge. step_idx holds its last value. Ticks in IDLE are ignored.
- Config write: registered on cfg_we. If cfg_we and step_tick occur in the same cycle, the fire uses the old pattern/prob and the new values apply from the next tick. An out-of-range cfg_ch is ignored.

Test Plan:
- Reset, channel 0 pattern 16'h0001 with prob all-ones, mode 0, length 4, run=1, 8 ticks -> step_idx 0,1,2,3,0,1,2,3; gate[0] high for 4 cycles after ticks 1 and 5 only.
- Mode 2, length 4, 8 ticks -> step_idx 0,1,2,3,2,1,0,1. Mode 1 from a fresh run -> 3,2,1,0,3.
- prob=0 with pattern all-ones -> gate stays 0 for 16 ticks. Prob all-ones -> 16 gates. Prob 8'h80 -> count matches a golden LFSR model seeded with 16'hACE1.
- Ticks every 2 cycles with GATE_LEN=4 -> gate[0] stays continuously high (retrigger), then falls 4 cycles after the last fire.
- Assert rst with gate high mid-run -> gate, running and step_idx go 0 immediately. After release, the first tick fires step 0.
- cfg_we in the same cycle as a tick (pattern 0 -> all-ones) -> no gate on that tick, gate on the next tick. Length cut 16->4 at pos 9 -> the next step is 0.
